// File: rtl/core_bus_pkg.sv
// Shared definitions for the core-to-AHB-Lite master bridge.
// Provides core size codes, AHB-Lite encodings, the bridge state type and
// small address helpers used by the request decoder.
package core_bus_pkg;

    // Core-side transfer size codes (ahb_size)
    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    // AHB-Lite encodings
    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [2:0] HBURST_SINGLE = 3'b000;
    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    // Bridge state encoding
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_ADDR = 2'b01,
        ST_DATA = 2'b10,
        ST_ERR2 = 2'b11
    } ahb_state_e;

    // True when the low address bits do not match the natural alignment of size.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic w_mis;
        w_mis = 1'b0;
        case (size)
            SZ_HALF: w_mis = addr_lo[0];
            SZ_WORD: w_mis = (addr_lo != 2'b00);
            default: w_mis = 1'b0;
        endcase
        return w_mis;
    endfunction

    // Clears the low address bits implied by size.
    function automatic logic [31:0] align_addr(input logic [31:0] addr, input logic [1:0] size);
        logic [31:0] w_a;
        w_a = addr;
        case (size)
            SZ_HALF: w_a = {addr[31:1], 1'b0};
            SZ_WORD: w_a = {addr[31:2], 2'b00};
            default: w_a = addr;
        endcase
        return w_a;
    endfunction

endpackage

// File: rtl/core_ahb_master_if.sv
// Bundles the core request port and the AHB-Lite master port of the bridge.
//   core side : ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size (to bridge)
//               ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err          (from bridge)
//   AHB side  : HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA (from bridge)
//               HRDATA, HREADY, HRESP                               (to bridge)
// modport master: the bridge's view; modport slave: the environment's view.
interface core_ahb_master_if;
    logic        ahb_rd_en;
    logic        ahb_wr_en;
    logic [31:0] ahb_addr;
    logic [31:0] ahb_wr_data;
    logic [1:0]  ahb_size;
    logic [31:0] ahb_rd_data;
    logic        ahb_rd_vld;
    logic        ahb_busy;
    logic        bus_err;

    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [2:0]  HBURST;
    logic [3:0]  HPROT;
    logic [31:0] HWDATA;
    logic [31:0] HRDATA;
    logic        HREADY;
    logic        HRESP;

    modport master (
        input  ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size,
        output ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err,
        output HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        input  HRDATA, HREADY, HRESP
    );

    modport slave (
        output ahb_rd_en, ahb_wr_en, ahb_addr, ahb_wr_data, ahb_size,
        input  ahb_rd_data, ahb_rd_vld, ahb_busy, bus_err,
        input  HADDR, HTRANS, HWRITE, HSIZE, HBURST, HPROT, HWDATA,
        output HRDATA, HREADY, HRESP
    );
endinterface

// File: rtl/ahb_lane_align.sv
// Combinational byte-lane steering for the AHB master bridge.
//   i_size    : core size code of the active transfer
//   i_addr_lo : HADDR[1:0] of the active transfer
//   i_hrdata  : raw AHB read data
//   i_wdata   : right-justified core write data
//   o_rdata   : selected read lane, right-justified and zero-extended
//   o_hwdata  : write data replicated across all lanes of the size
module ahb_lane_align
    import core_bus_pkg::*;
(
    input  logic [1:0]  i_size,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_hrdata,
    input  logic [31:0] i_wdata,
    output logic [31:0] o_rdata,
    output logic [31:0] o_hwdata
);

    always_comb begin
        o_rdata  = i_hrdata;
        o_hwdata = i_wdata;
        case (i_size)
            SZ_BYTE: begin
                o_rdata  = {24'h0, i_hrdata[{i_addr_lo, 3'b000} +: 8]};
                o_hwdata = {4{i_wdata[7:0]}};
            end
            SZ_HALF: begin
                o_rdata  = {16'h0, i_hrdata[{i_addr_lo[1], 4'b0000} +: 16]};
                o_hwdata = {2{i_wdata[15:0]}};
            end
            default: begin
                o_rdata  = i_hrdata;
                o_hwdata = i_wdata;
            end
        endcase
    end

endmodule

// File: rtl/core_ahb_master.sv
// Core-to-AHB-Lite single-master bridge. One SINGLE transfer in flight at a time.
//   clk, rst : clock and synchronous active-high reset
//   bus      : core request port and AHB-Lite master port (core_ahb_master_if.master)
// Illegal requests (both enables, reserved size, misalignment when ERR_ON_MISALIGN)
// are answered with a bus_err pulse and never reach the bus. All outputs are registered.
module core_ahb_master
    import core_bus_pkg::*;
#(
    parameter logic [3:0] HPROT_VAL       = 4'b0011,
    parameter bit         ERR_ON_MISALIGN = 1'b1
) (
    input logic               clk,
    input logic               rst,
    core_ahb_master_if.master bus
);

    ahb_state_e  r_state, w_state_nxt;

    logic [31:0] r_haddr, w_haddr_nxt;
    logic [1:0]  r_htrans, w_htrans_nxt;
    logic        r_hwrite, w_hwrite_nxt;
    logic [2:0]  r_hsize, w_hsize_nxt;
    logic [31:0] r_hwdata, w_hwdata_nxt;
    logic [31:0] r_wdata, w_wdata_nxt;
    logic [31:0] r_rd_data, w_rd_data_nxt;
    logic        r_rd_vld, w_rd_vld_nxt;
    logic        r_busy, w_busy_nxt;
    logic        r_bus_err, w_bus_err_nxt;

    logic        w_req;
    logic        w_bad;
    logic        w_accept;
    logic [31:0] w_lane_rdata;
    logic [31:0] w_lane_hwdata;

    // Request decode; only consulted while idle
    always_comb begin
        w_req    = bus.ahb_rd_en | bus.ahb_wr_en;
        w_bad    = w_req & ((bus.ahb_rd_en & bus.ahb_wr_en) | (bus.ahb_size == SZ_RSVD) |
                   (ERR_ON_MISALIGN & is_misaligned(bus.ahb_size, bus.ahb_addr[1:0])));
        w_accept = w_req & ~w_bad;
    end

    // Size and lane come from the registered address-phase signals
    ahb_lane_align u_lane_align (
        .i_size    (r_hsize[1:0]),
        .i_addr_lo (r_haddr[1:0]),
        .i_hrdata  (bus.HRDATA),
        .i_wdata   (r_wdata),
        .o_rdata   (w_lane_rdata),
        .o_hwdata  (w_lane_hwdata)
    );

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: if (w_accept) w_state_nxt = ST_ADDR;
            ST_ADDR: if (bus.HREADY) w_state_nxt = ST_DATA;
            ST_DATA: begin
                // HREADY high ends the transfer with either response
                if (bus.HREADY) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.HRESP == HRESP_ERROR) begin
                    w_state_nxt = ST_ERR2;
                end
            end
            ST_ERR2: if (bus.HREADY) w_state_nxt = ST_IDLE;
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Output next-values; pulses default low, everything else holds
    always_comb begin
        w_haddr_nxt   = r_haddr;
        w_htrans_nxt  = r_htrans;
        w_hwrite_nxt  = r_hwrite;
        w_hsize_nxt   = r_hsize;
        w_hwdata_nxt  = r_hwdata;
        w_wdata_nxt   = r_wdata;
        w_rd_data_nxt = r_rd_data;
        w_busy_nxt    = r_busy;
        w_rd_vld_nxt  = 1'b0;
        w_bus_err_nxt = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_haddr_nxt  = align_addr(bus.ahb_addr, bus.ahb_size);
                    w_hwrite_nxt = bus.ahb_wr_en;
                    w_hsize_nxt  = {1'b0, bus.ahb_size};
                    w_htrans_nxt = HTRANS_NONSEQ;
                    w_wdata_nxt  = bus.ahb_wr_data;
                    w_busy_nxt   = 1'b1;
                end else if (w_bad) begin
                    w_bus_err_nxt = 1'b1;
                end
            end
            ST_ADDR: begin
                if (bus.HREADY) begin
                    w_htrans_nxt = HTRANS_IDLE;
                    if (r_hwrite) w_hwdata_nxt = w_lane_hwdata;
                end
            end
            ST_DATA: begin
                if (bus.HREADY) begin
                    w_busy_nxt = 1'b0;
                    if (bus.HRESP == HRESP_ERROR) begin
                        w_bus_err_nxt = 1'b1;
                    end else if (!r_hwrite) begin
                        w_rd_data_nxt = w_lane_rdata;
                        w_rd_vld_nxt  = 1'b1;
                    end
                end
            end
            ST_ERR2: begin
                if (bus.HREADY) begin
                    w_busy_nxt    = 1'b0;
                    w_bus_err_nxt = 1'b1;
                end
            end
            default: ;
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_haddr   <= 32'h0;
            r_htrans  <= HTRANS_IDLE;
            r_hwrite  <= 1'b0;
            r_hsize   <= 3'b000;
            r_hwdata  <= 32'h0;
            r_wdata   <= 32'h0;
            r_rd_data <= 32'h0;
            r_rd_vld  <= 1'b0;
            r_busy    <= 1'b0;
            r_bus_err <= 1'b0;
        end else begin
            r_haddr   <= w_haddr_nxt;
            r_htrans  <= w_htrans_nxt;
            r_hwrite  <= w_hwrite_nxt;
            r_hsize   <= w_hsize_nxt;
            r_hwdata  <= w_hwdata_nxt;
            r_wdata   <= w_wdata_nxt;
            r_rd_data <= w_rd_data_nxt;
            r_rd_vld  <= w_rd_vld_nxt;
            r_busy    <= w_busy_nxt;
            r_bus_err <= w_bus_err_nxt;
        end
    end

    assign bus.HADDR       = r_haddr;
    assign bus.HTRANS      = r_htrans;
    assign bus.HWRITE      = r_hwrite;
    assign bus.HSIZE       = r_hsize;
    assign bus.HBURST      = HBURST_SINGLE;
    assign bus.HPROT       = HPROT_VAL;
    assign bus.HWDATA      = r_hwdata;
    assign bus.ahb_rd_data = r_rd_data;
    assign bus.ahb_rd_vld  = r_rd_vld;
    assign bus.ahb_busy    = r_busy;
    assign bus.bus_err     = r_bus_err;

endmodule

// File: tb/tb_core_ahb_master.sv
// Bench for core_ahb_master: directed scenarios plus randomized transactions.
// Expected outputs are derived per transaction from its timeline and checked every cycle.
module tb_core_ahb_master;

    logic clk;
    logic rst;
    int   n_checks;
    int   n_errors;
    bit   chk_en;

    core_ahb_master_if bus ();

    core_ahb_master #(
        .HPROT_VAL       (4'b0011),
        .ERR_ON_MISALIGN (1'b1)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Expected DUT outputs for the cycle following the next rising edge
    logic [31:0] exp_rd_data, exp_haddr, exp_hwdata;
    logic        exp_rd_vld, exp_busy, exp_bus_err, exp_hwrite;
    logic [1:0]  exp_htrans;
    logic [2:0]  exp_hsize;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_checks++;
        if (act !== expv) begin
            n_errors++;
            if (n_errors <= 50)
                $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    always @(posedge clk) begin
        #2;
        if (chk_en) begin
            chk("rd_data", bus.ahb_rd_data, exp_rd_data);
            chk("rd_vld", 32'(bus.ahb_rd_vld), 32'(exp_rd_vld));
            chk("busy", 32'(bus.ahb_busy), 32'(exp_busy));
            chk("bus_err", 32'(bus.bus_err), 32'(exp_bus_err));
            chk("HADDR", bus.HADDR, exp_haddr);
            chk("HTRANS", 32'(bus.HTRANS), 32'(exp_htrans));
            chk("HWRITE", 32'(bus.HWRITE), 32'(exp_hwrite));
            chk("HSIZE", 32'(bus.HSIZE), 32'(exp_hsize));
            chk("HBURST", 32'(bus.HBURST), 32'h0);
            chk("HPROT", 32'(bus.HPROT), 32'h3);
            chk("HWDATA", bus.HWDATA, exp_hwdata);
        end
    end

    function automatic logic [31:0] lane_rd(input logic [31:0] d, input logic [31:0] a,
                                            input logic [1:0] sz);
        if (sz == 2'b00) return (d >> (8 * a[1:0])) & 32'h0000_00FF;
        if (sz == 2'b01) return (d >> (16 * a[1])) & 32'h0000_FFFF;
        return d;
    endfunction

    function automatic logic [31:0] lane_wr(input logic [31:0] w, input logic [1:0] sz);
        if (sz == 2'b00) return {24'h0, w[7:0]} * 32'h0101_0101;
        if (sz == 2'b01) return {16'h0, w[15:0]} * 32'h0001_0001;
        return w;
    endfunction

    task automatic model_reset();
        exp_rd_data = 32'h0; exp_haddr = 32'h0; exp_hwdata = 32'h0;
        exp_rd_vld = 1'b0; exp_busy = 1'b0; exp_bus_err = 1'b0; exp_hwrite = 1'b0;
        exp_htrans = 2'b00; exp_hsize = 3'b000;
    endtask

    task automatic step();
        @(negedge clk);
    endtask

    // Random request noise while busy, plus random read data
    task automatic junk();
        logic [31:0] r;
        r = $urandom;
        bus.ahb_rd_en   = r[0];
        bus.ahb_wr_en   = r[1];
        bus.ahb_size    = r[3:2];
        bus.ahb_addr    = $urandom;
        bus.ahb_wr_data = $urandom;
        bus.HRDATA      = $urandom;
    endtask

    task automatic idle(input int n);
        bus.ahb_rd_en = 1'b0;
        bus.ahb_wr_en = 1'b0;
        bus.HREADY    = 1'b1;
        bus.HRESP     = 1'b0;
        exp_rd_vld    = 1'b0;
        exp_bus_err   = 1'b0;
        repeat (n) step();
    endtask

    // err_mode: 0 okay, 1 two-cycle ERROR, 2 HREADY+HRESP in one cycle, 3 reset in data wait
    task automatic do_xfer(input logic rd, input logic wr, input logic [31:0] addr,
                           input logic [1:0] size, input logic [31:0] wdata,
                           input logic [31:0] hrdata, input int n_aw, input int n_dw,
                           input int err_mode);
        logic mis;
        logic bad;
        logic [31:0] r;
        int ndw;
        ndw = n_dw;
        if (err_mode == 3 && ndw == 0) ndw = 1;
        mis = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
        bad = (rd && wr) || (size == 2'b11) || mis;
        r = $urandom;
        bus.ahb_rd_en   = rd;
        bus.ahb_wr_en   = wr;
        bus.ahb_addr    = addr;
        bus.ahb_size    = size;
        bus.ahb_wr_data = wdata;
        bus.HREADY      = r[0];
        bus.HRESP       = 1'b0;
        bus.HRDATA      = $urandom;
        rst             = 1'b0;
        exp_rd_vld      = 1'b0;
        exp_bus_err     = 1'b0;
        if (!rd && !wr) begin
            step();
            return;
        end
        if (bad) begin
            exp_bus_err = 1'b1;
            step();
            return;
        end
        exp_busy   = 1'b1;
        exp_htrans = 2'b10;
        exp_haddr  = addr;
        exp_hwrite = wr;
        exp_hsize  = {1'b0, size};
        step();
        // Address phase
        for (int i = 0; i < n_aw; i++) begin
            junk();
            bus.HREADY = 1'b0;
            step();
        end
        junk();
        bus.HREADY = 1'b1;
        exp_htrans = 2'b00;
        if (wr) exp_hwdata = lane_wr(wdata, size);
        step();
        // Data phase wait states
        for (int i = 0; i < ndw; i++) begin
            junk();
            bus.HREADY = 1'b0;
            bus.HRESP  = 1'b0;
            step();
        end
        junk();
        case (err_mode)
            1: begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b1;
                step();
                junk();
                bus.HREADY  = 1'b1;
                bus.HRESP   = 1'b1;
                exp_busy    = 1'b0;
                exp_bus_err = 1'b1;
                step();
            end
            2: begin
                bus.HREADY  = 1'b1;
                bus.HRESP   = 1'b1;
                exp_busy    = 1'b0;
                exp_bus_err = 1'b1;
                step();
            end
            3: begin
                bus.HREADY = 1'b0;
                bus.HRESP  = 1'b0;
                rst        = 1'b1;
                model_reset();
                step();
                rst = 1'b0;
            end
            default: begin
                bus.HREADY = 1'b1;
                bus.HRESP  = 1'b0;
                bus.HRDATA = hrdata;
                exp_busy   = 1'b0;
                if (!wr) begin
                    exp_rd_vld  = 1'b1;
                    exp_rd_data = lane_rd(hrdata, addr, size);
                end
                step();
            end
        endcase
    endtask

    initial begin
        logic rd;
        logic wr;
        logic [1:0] sz;
        logic [31:0] a;
        int unsigned t;
        int em;
        n_checks = 0;
        n_errors = 0;
        rst = 1'b1;
        bus.ahb_rd_en = 1'b0; bus.ahb_wr_en = 1'b0; bus.ahb_addr = 32'h0;
        bus.ahb_wr_data = 32'h0; bus.ahb_size = 2'b00;
        bus.HRDATA = 32'h0; bus.HREADY = 1'b1; bus.HRESP = 1'b0;
        model_reset();
        chk_en = 1'b1;
        step();
        step();
        rst = 1'b0;
        idle(2);
        chk("reset HTRANS", 32'(bus.HTRANS), 32'h0);
        chk("reset busy", 32'(bus.ahb_busy), 32'h0);
        chk("reset rd_data", bus.ahb_rd_data, 32'h0);

        // Word read, no waits
        do_xfer(1'b1, 1'b0, 32'h0000_1004, 2'b10, 32'h0, 32'hDEAD_BEEF, 0, 0, 0);
        chk("word rd_data", bus.ahb_rd_data, 32'hDEAD_BEEF);
        chk("word rd_vld", 32'(bus.ahb_rd_vld), 32'h1);
        chk("word HSIZE", 32'(bus.HSIZE), 32'h2);
        // Byte and halfword lanes
        do_xfer(1'b1, 1'b0, 32'h0000_2003, 2'b00, 32'h0, 32'hA1B2_C3D4, 0, 0, 0);
        chk("byte rd_data", bus.ahb_rd_data, 32'h0000_00A1);
        do_xfer(1'b1, 1'b0, 32'h0000_2002, 2'b01, 32'h0, 32'hA1B2_C3D4, 0, 0, 0);
        chk("half rd_data", bus.ahb_rd_data, 32'h0000_A1B2);
        // Halfword write with two data wait states
        do_xfer(1'b0, 1'b1, 32'h0000_3006, 2'b01, 32'h0000_1234, 32'h0, 0, 2, 0);
        chk("half HWDATA", bus.HWDATA, 32'h1234_1234);
        chk("write rd_vld", 32'(bus.ahb_rd_vld), 32'h0);
        chk("write busy", 32'(bus.ahb_busy), 32'h0);
        // Two-cycle error response
        do_xfer(1'b1, 1'b0, 32'h0000_1008, 2'b10, 32'h0, 32'h0, 0, 0, 1);
        chk("err bus_err", 32'(bus.bus_err), 32'h1);
        chk("err rd_vld", 32'(bus.ahb_rd_vld), 32'h0);
        chk("err rd_data", bus.ahb_rd_data, 32'h0000_A1B2);
        // Rejected requests
        do_xfer(1'b1, 1'b0, 32'h0000_1002, 2'b10, 32'h0, 32'h0, 0, 0, 0);
        chk("misalign bus_err", 32'(bus.bus_err), 32'h1);
        chk("misalign HTRANS", 32'(bus.HTRANS), 32'h0);
        do_xfer(1'b1, 1'b0, 32'h0000_1000, 2'b11, 32'h0, 32'h0, 0, 0, 0);
        chk("rsvd bus_err", 32'(bus.bus_err), 32'h1);
        do_xfer(1'b1, 1'b1, 32'h0000_1000, 2'b10, 32'h0, 32'h0, 0, 0, 0);
        chk("both bus_err", 32'(bus.bus_err), 32'h1);
        chk("both busy", 32'(bus.ahb_busy), 32'h0);
        // Reset during data-phase wait states, then a fresh read
        do_xfer(1'b1, 1'b0, 32'h0000_4000, 2'b10, 32'h0, 32'h0, 0, 2, 3);
        chk("rst HTRANS", 32'(bus.HTRANS), 32'h0);
        chk("rst busy", 32'(bus.ahb_busy), 32'h0);
        chk("rst bus_err", 32'(bus.bus_err), 32'h0);
        do_xfer(1'b1, 1'b0, 32'h0000_5008, 2'b10, 32'h0, 32'h0BAD_F00D, 1, 1, 0);
        chk("post-rst rd_data", bus.ahb_rd_data, 32'h0BAD_F00D);
        idle(2);

        // Randomized transactions
        for (int n = 0; n < 400; n++) begin
            t = $urandom_range(0, 99);
            rd = (t < 5) || (t >= 10 && t < 55);
            wr = (t < 5) || (t >= 55);
            t = $urandom_range(0, 19);
            if (t == 0) sz = 2'b11;
            else begin
                t = $urandom_range(0, 2);
                sz = t[1:0];
            end
            a = $urandom;
            if ($urandom_range(0, 3) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            t = $urandom_range(0, 9);
            em = (t < 7) ? 0 : int'(t) - 6;
            do_xfer(rd, wr, a, sz, $urandom, $urandom, $urandom_range(0, 2),
                    $urandom_range(0, 3), em);
            if ($urandom_range(0, 7) == 0) idle(1);
        end
        idle(3);
        chk_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/core_ahb_master.md
Name: core_ahb_master

Overview:
- Bridges the processor core's simple bus request port onto a single-master AHB-Lite bus toward the SoC interconnect.
- Sits directly downstream of core. It consumes ahb_rd_en / ahb_wr_en / ahb_addr / ahb_wr_data / ahb_size and produces ahb_rd_data / ahb_rd_vld / ahb_busy.
- Handles exactly one outstanding SINGLE transfer at a time. Covers alignment checks, byte-lane steering, wait states and two-cycle ERROR responses.
- Reports faulted accesses with bus_err, which the SoC routes to the core's ir_data_process abort input.

Parameters:
- HPROT_VAL, 4'b0011, constant HPROT driven on every transfer (data, privileged).
- ERR_ON_MISALIGN, 1, 1 = misaligned request faults with no bus cycle; 0 = address is force-aligned (low bits cleared) and the transfer is issued.

Ports:
- clk  in  1  single clock, all logic on its rising edge
- rst  in  1  reset, synchronous, active-high
- ahb_rd_en  in  1  read request from core, sampled only when ahb_busy=0
- ahb_wr_en  in  1  write request from core, sampled only when ahb_busy=0
- ahb_addr  in  32  byte address
- ahb_wr_data  in  32  write data, right-justified
- ahb_size  in  2  00 byte, 01 halfword, 10 word, 11 reserved
- ahb_rd_data  out  32  read data, right-justified, zero-extended
- ahb_rd_vld  out  1  one-cycle pulse, ahb_rd_data valid
- ahb_busy  out  1  transfer in flight; new requests ignored
- bus_err  out  1  one-cycle pulse, request faulted
- HADDR  out  32;  HTRANS  out  2;  HWRITE  out  1;  HSIZE  out  3;  HBURST  out  3 (tied 000 SINGLE);  HPROT  out  4
- HWDATA  out  32;  HRDATA  in  32;  HREADY  in  1;  HRESP  in  1

Behaviour:
- Reset values: state IDLE; HTRANS=IDLE(00); HADDR, HWDATA, HSIZE, HWRITE = 0; ahb_rd_data=0; ahb_rd_vld, ahb_busy, bus_err = 0.
- All outputs are registered.
- States: IDLE, ADDR, DATA, ERR2.
- IDLE:
  - Request (rd_en xor wr_en, size != 11, aligned) at edge T0: latch addr/size/dir/data and go to ADDR.
  - ahb_busy=1 from T1.
  - Misaligned (half with addr[0]=1; word with addr[1:0] != 0, when ERR_ON_MISALIGN=1), size=11, or rd_en&wr_en both set: no bus cycle, bus_err=1 in T1, stay IDLE.
- ADDR: HTRANS=NONSEQ, HADDR/HWRITE/HSIZE (= {1'b0, size}) driven. If HREADY=1 at clock end, go to DATA; otherwise hold all address-phase signals.
- DATA:
  - HTRANS=IDLE. HWDATA = write data replicated across lanes (byte x4, halfword x2).
  - HREADY=1 & HRESP=0: complete. For reads, capture the HRDATA lane (byte: addr[1:0]; half: addr[1]), zero-extend, and pulse ahb_rd_vld next cycle. Return to IDLE; ahb_busy=0 in the same cycle as the rd_vld pulse.
  - HREADY=0 & HRESP=0: wait state, hold HWDATA, unbounded.
  - HREADY=0 & HRESP=1: go to ERR2.
- ERR2: on HREADY=1, pulse bus_err, no rd_vld, return to IDLE. HRESP=1 with HREADY=1 directly in DATA is also treated as an error completion.
- Writes complete silently: no rd_vld, busy drops.
- Zero-wait latency: read request T0, ADDR T1, DATA T2, rd_vld/busy=0 in T3. Next request is accepted at edge T3, giving a 3-cycle throughput.
- ahb_rd_data holds its last value until the next read completes.
- rst asserted in any state: next cycle returns to reset values. An in-flight transfer is abandoned; HTRANS goes IDLE and no rd_vld or bus_err is issued.

Decomposition:
- Package core_bus_pkg:
  - core size codes (SZ_BYTE/HALF/WORD)
  - HTRANS_IDLE/NONSEQ, HBURST_SINGLE, HRESP_OKAY/ERROR
  - state encoding (ST_IDLE/ADDR/DATA/ERR2)
- One combinational sub-module, ahb_lane_align: read-lane extraction/zero-extension and write-lane replication from size + addr[1:0].

Test Plan:
- Word read, addr 0x0000_1004, HREADY always 1, HRDATA=0xDEADBEEF -> HTRANS NONSEQ in T1, HSIZE=010; rd_vld in T3 with rd_data=0xDEADBEEF; busy high in T1-T2 only.
- Byte read, addr 0x..03, HRDATA=0xA1B2C3D4 -> rd_data=0x000000A1. Halfword read, addr 0x..02 -> rd_data=0x0000A1B2.
- Halfword write 0x1234 to 0x..06, with 2 wait states (HREADY=0) in the data phase -> HWDATA=0x12341234 held 3 cycles; no rd_vld; busy falls after the HREADY=1 cycle.
- Word read with HREADY=0/HRESP=1 then HREADY=1/HRESP=1 -> bus_err pulse for 1 cycle; rd_vld never asserted; rd_data unchanged.
- Word read at 0x..02 (ERR_ON_MISALIGN=1); separately size=11; separately rd_en&wr_en=1 -> HTRANS stays IDLE; bus_err in T1; busy stays 0.
- rst asserted in the DATA phase during wait states -> next cycle HTRANS=00, busy=0, no rd_vld/bus_err; a following fresh read completes normally.
